// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: framed UART command decoder driving a single memory port (writes, burst reads, status)
module uart_mem_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_BYTES      = 2,
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_stb,
  output logic [7:0]            tx_data,
  output logic                  tx_stb,
  input  logic                  tx_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dw,
  input  logic [DATA_WIDTH-1:0] mem_dr,
  output logic                  busy,
  output logic                  err
);
  localparam int AB = ADDR_WIDTH / 8;
  localparam int DB = DATA_WIDTH / 8;
  localparam int LW = 8 * LEN_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, ADDR, LEN, WDATA, WRITE, RREQ, RWAIT, RSEND, RESP} state_t;
  state_t state;
  logic is_w;
  logic [LW-1:0] cnt;
  logic [DATA_WIDTH-1:0] rd;
  logic [7:0] bcnt;
  logic [1:0] lat;
  logic [TW-1:0] tmo;
  logic in_frame, blast;
  always_comb begin
    in_frame = state inside {ADDR, LEN, WDATA};
    blast = bcnt == 8'((state == ADDR ? AB : state == LEN ? LEN_BYTES : DB) - 1);
  end
  assign busy = state != IDLE;
  // mem_addr and mem_dw double as the address and write-word shift registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      is_w     <= 1'b0;
      cnt      <= '0;
      rd       <= '0;
      bcnt     <= '0;
      lat      <= '0;
      tmo      <= '0;
      tx_data  <= '0;
      tx_stb   <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dw   <= '0;
      err      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      tmo    <= (rx_stb || !in_frame) ? '0 : tmo + 1'b1;
      if (in_frame && !rx_stb && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        err   <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rx_stb) begin
            bcnt <= '0;
            if (rx_data == 8'h57 || rx_data == 8'h52) begin
              is_w  <= rx_data == 8'h57;
              state <= ADDR;
            end else if (rx_data == 8'h53) begin
              tx_data <= {6'b0, err, 1'b0};
              tx_stb  <= 1'b1;
              err     <= 1'b0;
              state   <= RESP;
            end else err <= 1'b1;
          end
          ADDR: if (rx_stb) begin
            mem_addr <= (mem_addr << 8) | ADDR_WIDTH'(rx_data);
            bcnt     <= blast ? 8'd0 : bcnt + 8'd1;
            state    <= blast ? LEN : ADDR;
          end
          LEN: if (rx_stb) begin
            cnt  <= (cnt << 8) | LW'(rx_data);
            bcnt <= blast ? 8'd0 : bcnt + 8'd1;
            if (blast) begin
              state  <= is_w ? WDATA : RREQ;
              mem_en <= !is_w;
            end
          end
          WDATA: if (rx_stb) begin
            mem_dw <= (mem_dw << 8) | DATA_WIDTH'(rx_data);
            bcnt   <= blast ? 8'd0 : bcnt + 8'd1;
            if (blast) begin
              mem_en <= 1'b1;
              mem_we <= 1'b1;
              state  <= WRITE;
            end
          end
          WRITE: begin
            mem_addr <= mem_addr + 1'b1;
            if (cnt == '0) begin
              tx_data <= 8'h4B;
              tx_stb  <= 1'b1;
              state   <= RESP;
            end else begin
              cnt   <= cnt - 1'b1;
              state <= WDATA;
            end
          end
          RREQ: begin
            lat   <= 2'd1;
            state <= RWAIT;
          end
          RWAIT: if (lat == 2'(MEM_LATENCY)) begin
            tx_data <= mem_dr[DATA_WIDTH-1 -: 8];
            rd      <= mem_dr << 8;
            tx_stb  <= 1'b1;
            bcnt    <= '0;
            state   <= RSEND;
          end else lat <= lat + 2'd1;
          RSEND: if (tx_ack && tx_stb) begin
            if (blast) begin
              bcnt   <= '0;
              tx_stb <= 1'b0;
              if (cnt != '0) begin
                cnt      <= cnt - 1'b1;
                mem_addr <= mem_addr + 1'b1;
                mem_en   <= 1'b1;
                state    <= RREQ;
              end else state <= IDLE;
            end else begin
              bcnt    <= bcnt + 8'd1;
              tx_data <= rd[DATA_WIDTH-1 -: 8];
              rd      <= rd << 8;
            end
          end
          RESP: if (tx_ack && tx_stb) begin
            tx_stb <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: directed scenario bench for uart_mem_bridge with a latency-1 memory model
module tb_uart_mem_bridge;
  logic clk = 0, reset = 1, rx_stb = 0, tx_ack = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic tx_stb, mem_en, mem_we, busy, err;
  logic [15:0] mem_addr;
  logic [31:0] mem_dw, mem_dr;
  logic [31:0] mem [0:65535];
  logic [47:0] wlog [$];
  int rd_n = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_mem_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dw(mem_dw), .mem_dr(mem_dr), .busy(busy), .err(err)
  );

  always @(posedge clk) if (mem_en) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_dw;
      wlog.push_back({mem_addr, mem_dw});
    end else begin
      mem_dr <= mem[mem_addr];
      rd_n <= rd_n + 1;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_stb = 1;
    @(negedge clk); rx_stb = 0;
  endtask

  task automatic get_byte(input int hold, output logic [7:0] b, output logic stable);
    int n = 0;
    stable = 1;
    while (!tx_stb && n < 300) begin @(negedge clk); n++; end
    if (!tx_stb) begin b = 8'hxx; stable = 0; return; end
    b = tx_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!tx_stb || tx_data !== b) stable = 0;
    end
    tx_ack = 1; @(negedge clk); tx_ack = 0;
  endtask

  function automatic logic [47:0] wl(input int i);
    return (wlog.size() > i) ? wlog[i] : 48'hx;
  endfunction

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    total++; if ({tx_stb, mem_en, mem_we, busy, err, tx_data, mem_addr, mem_dw} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {tx_stb, mem_en, mem_we, busy, err, tx_data, mem_addr, mem_dw}); end
    reset = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read;
    logic [7:0] wf [9] = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] rf [5] = '{8'h52, 8'h00, 8'h10, 8'h00, 8'h00};
    logic [31:0] exp = 32'hDEADBEEF;
    logic [7:0] b; logic s;
    int w0 = wlog.size(), r0 = rd_n;
    foreach (wf[i]) send(wf[i]);
    get_byte(0, b, s);
    total++; if (b !== 8'h4B) begin bad++; $display("FAIL wr_resp got=%h exp=4b", b); end
    total++; if (wlog.size() - w0 != 1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wlog.size() - w0); end
    total++; if (wl(w0) !== {16'h0010, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_addr_data got=%h exp=0010deadbeef", wl(w0)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
    foreach (rf[i]) send(rf[i]);
    for (int i = 0; i < 4; i++) begin
      get_byte(0, b, s);
      total++; if (b !== exp[31-8*i -: 8]) begin bad++; $display("FAIL rd_byte%0d got=%h exp=%h", i, b, exp[31-8*i -: 8]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
    total++; if (rd_n - r0 != 1) begin bad++; $display("FAIL rd_reqs got=%0d exp=1", rd_n - r0); end
  endtask

  task automatic test_wrap;
    logic [7:0] wf [13] = '{8'h57, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    logic [7:0] rf [5] = '{8'h52, 8'hFF, 8'hFF, 8'h00, 8'h01};
    logic [7:0] b; logic s;
    int w0 = wlog.size();
    foreach (wf[i]) send(wf[i]);
    get_byte(0, b, s);
    total++; if (b !== 8'h4B) begin bad++; $display("FAIL wrap_resp got=%h exp=4b", b); end
    total++; if (wlog.size() - w0 != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", wlog.size() - w0); end
    total++; if (wl(w0) !== {16'hFFFF, 32'h11111111}) begin bad++; $display("FAIL wrap_w0 got=%h exp=ffff11111111", wl(w0)); end
    total++; if (wl(w0 + 1) !== {16'h0000, 32'h22222222}) begin bad++; $display("FAIL wrap_w1 got=%h exp=000022222222", wl(w0 + 1)); end
    repeat (5) @(negedge clk);
    total++; if (tx_stb !== 1'b0) begin bad++; $display("FAIL wrap_single_k got=%b exp=0", tx_stb); end
    foreach (rf[i]) send(rf[i]);
    for (int i = 0; i < 8; i++) begin
      get_byte(0, b, s);
      total++; if (b !== (i < 4 ? 8'h11 : 8'h22)) begin bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, b, (i < 4 ? 8'h11 : 8'h22)); end
    end
  endtask

  task automatic test_slow_consumer;
    logic [7:0] wf [13] = '{8'h57, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] rf [5] = '{8'h52, 8'h01, 8'h00, 8'h00, 8'h01};
    logic [7:0] b; logic s;
    int r0;
    foreach (wf[i]) send(wf[i]);
    get_byte(0, b, s);
    total++; if (b !== 8'h4B) begin bad++; $display("FAIL slow_wr_resp got=%h exp=4b", b); end
    r0 = rd_n;
    foreach (rf[i]) send(rf[i]);
    for (int i = 0; i < 8; i++) begin
      get_byte(20, b, s);
      total++; if (b !== 8'(i + 1)) begin bad++; $display("FAIL slow_rd%0d got=%h exp=%h", i, b, 8'(i + 1)); end
      total++; if (s !== 1'b1) begin bad++; $display("FAIL slow_stable%0d got=%b exp=1", i, s); end
    end
    repeat (5) @(negedge clk);
    total++; if (tx_stb !== 1'b0) begin bad++; $display("FAIL slow_extra_byte got=%b exp=0", tx_stb); end
    total++; if (rd_n - r0 != 2) begin bad++; $display("FAIL slow_rreqs got=%0d exp=2", rd_n - r0); end
  endtask

  task automatic test_bad_status;
    logic [7:0] b; logic s;
    int w0 = wlog.size(), r0 = rd_n;
    send(8'h41);
    repeat (2) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b exp=1", err); end
    total++; if (wlog.size() - w0 + rd_n - r0 != 0) begin bad++; $display("FAIL bad_mem_access got=%0d exp=0", wlog.size() - w0 + rd_n - r0); end
    send(8'h53);
    get_byte(0, b, s);
    total++; if (b !== 8'h02) begin bad++; $display("FAIL status1 got=%h exp=02", b); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL status_clr got=%b exp=0", err); end
    send(8'h53);
    get_byte(0, b, s);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL status2 got=%h exp=00", b); end
  endtask

  task automatic test_timeout;
    logic [7:0] pf [7] = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h00, 8'hAA, 8'hBB};
    logic [7:0] b; logic s;
    int w0 = wlog.size();
    foreach (pf[i]) send(pf[i]);
    repeat (99) @(negedge clk);
    total++; if ({err, busy} !== 2'b01) begin bad++; $display("FAIL tmo_early got=%b exp=01", {err, busy}); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b exp=0", busy); end
    total++; if (wlog.size() != w0) begin bad++; $display("FAIL tmo_no_write got=%0d exp=%0d", wlog.size(), w0); end
    foreach (pf[i]) send(pf[i]);
    send(8'hCC); send(8'hDD);
    get_byte(0, b, s);
    total++; if (b !== 8'h4B) begin bad++; $display("FAIL tmo_next_resp got=%h exp=4b", b); end
    total++; if (wl(w0) !== {16'h0020, 32'hAABBCCDD}) begin bad++; $display("FAIL tmo_next_write got=%h exp=0020aabbccdd", wl(w0)); end
    send(8'h53);
    get_byte(0, b, s);
    total++; if (b !== 8'h02) begin bad++; $display("FAIL tmo_status got=%h exp=02", b); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rf [5] = '{8'h52, 8'h00, 8'h10, 8'h00, 8'h00};
    logic [7:0] b; logic s;
    int r0;
    logic en_seen = 0;
    send(8'h41);
    foreach (rf[i]) send(rf[i]);
    get_byte(0, b, s);
    total++; if (b !== 8'hDE) begin bad++; $display("FAIL rst_first got=%h exp=de", b); end
    total++; if ({tx_stb, err} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b exp=11", {tx_stb, err}); end
    reset = 1; @(negedge clk); reset = 0;
    total++; if ({tx_stb, busy, err, mem_en} !== 4'b0) begin bad++; $display("FAIL rst_mid got=%b exp=0000", {tx_stb, busy, err, mem_en}); end
    r0 = rd_n;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en || tx_stb) en_seen = 1;
    end
    total++; if (en_seen !== 1'b0 || rd_n != r0) begin bad++; $display("FAIL rst_quiet got=%b exp=0", en_seen); end
    send(8'h53);
    get_byte(0, b, s);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", b); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_wrap;
    test_slow_consumer;
    test_bad_status;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
